// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch port, the data port, the shared memory port and the two
//   pipeline stall lines that connect to mem_port_arbiter.
//
//   Fetch port  : if_req, if_addr            -> arbiter
//                 if_rdata, if_done          <- arbiter
//   Data port   : d_req, d_we, d_addr,
//                 d_wdata                    -> arbiter
//                 d_rdata, d_done            <- arbiter
//   Memory port : mem_req, mem_we, mem_addr,
//                 mem_wdata                  <- arbiter
//                 mem_rdata, mem_ready       -> arbiter
//   Stalls      : stall_if, stall_mem        <- arbiter
//
//   modport master : the arbiter's view
//   modport slave  : the surrounding pipeline / memory view
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        stall_if;
    logic        stall_mem;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, d_rdata, d_done,
               mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, d_rdata, d_done,
               mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between the instruction fetch port and the
//   data (load/store) port. One transaction is outstanding at a time. Data
//   requests win ties, but after STARVE_MAX consecutive data grants made while
//   a fetch waits, the fetch is served next.
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous, active-high reset
//     bus  - mem_port_arbiter_if.master (fetch, data, memory, stall signals)
//
//   Parameter:
//     STARVE_MAX - max consecutive data grants while a fetch is pending (1..7)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_port_arbiter_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        grant_d;
    logic        grant_i;
    logic        if_done_w;
    logic        d_done_w;

    // Data wins unless a fetch has already been passed over STARVE_MAX times.
    assign grant_d = bus.d_req & (~bus.if_req | (starve_cnt_q < STARVE_LIM));
    assign grant_i = bus.if_req & ~grant_d;

    // NOTE: every variable assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (grant_i) begin
                    state_d     = BUSY_I;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                end

                // Count only data grants that bypass a waiting fetch.
                if (!bus.if_req) begin
                    starve_cnt_d = '0;
                end else if (grant_d) begin
                    starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM
                                                                : starve_cnt_q + 3'd1;
                end else if (grant_i) begin
                    starve_cnt_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Completion is suppressed while rst is high so an abandoned transaction
    // never reports done, even if the memory answers in the reset cycle.
    assign if_done_w = (state_q == BUSY_I) & bus.mem_ready & ~rst;
    assign d_done_w  = (state_q == BUSY_D) & bus.mem_ready & ~rst;

    assign bus.if_done   = if_done_w;
    assign bus.d_done    = d_done_w;
    assign bus.if_rdata  = if_done_w ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_done_w  ? bus.mem_rdata : '0;

    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign bus.stall_if  = bus.if_req & ~if_done_w;
    assign bus.stall_mem = bus.d_req & ~d_done_w;

endmodule
